// File: rtl/mnist_conv_pool.sv
`default_nettype none
// ==========================================================================
// mnist_conv_pool : ROM-fed 4 x (3x3) float convolution, ReLU, 2x2 max-pool
// Revision: 1.0
// ==========================================================================
module mnist_conv_pool #(
  parameter int KERNEL_SIZE    = 3,
  parameter int ARRAY_SIZE     = 6,
  parameter int TOTAL_WEIGHT   = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int EXT_ADDR_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [EXT_ADDR_WIDTH-1:0]   ext_rom_addr,
  output logic [12*DATA_WIDTH-1:0]    pooling_output
);

  localparam int IMG_EDGE = ARRAY_SIZE + KERNEL_SIZE - 1;
  localparam int NUM_W    = TOTAL_WEIGHT * KERNEL_SIZE * KERNEL_SIZE;
  localparam int NUM_PIX  = IMG_EDGE * IMG_EDGE;
  localparam int NUM_SLOT = TOTAL_WEIGHT * ARRAY_SIZE / 2;
  localparam int WI_W     = $clog2(NUM_W);
  localparam int PI_W     = $clog2(NUM_PIX);
  localparam int SI_W     = $clog2(NUM_SLOT);
  localparam logic [EXT_ADDR_WIDTH-1:0] W_LAST   = EXT_ADDR_WIDTH'(NUM_W - 1);
  localparam logic [EXT_ADDR_WIDTH-1:0] IMG_BASE = EXT_ADDR_WIDTH'(NUM_W);
  localparam logic [EXT_ADDR_WIDTH-1:0] IMG_LAST = EXT_ADDR_WIDTH'(NUM_W + NUM_PIX - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_IMG, S_COMPUTE, S_DONE} state_e;

  // Denormal inputs are flushed to zero; rounding is round-to-nearest-even.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]        p;
    logic [24:0]        m;
    logic signed [9:0]  e;
    logic               g, st;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m = {1'b0, p[47:24]}; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
    end else begin
      m = {1'b0, p[46:23]}; g = p[22]; st = |p[21:0];
    end
    m = m + {24'd0, g & (st | m[0])};
    if (m[24]) begin m = m >> 1; e = e + 10'sd1; end
    if (e <= 10'sd0)   return {a[31] ^ b[31], 31'd0};
    if (e >= 10'sd255) return {a[31] ^ b[31], 8'hFF, 23'd0};
    return {a[31] ^ b[31], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        x, y;
    logic [7:0]         d;
    logic [26:0]        mx, my, sh;
    logic [27:0]        s;
    logic [24:0]        m;
    logic signed [9:0]  e;
    logic               rnd;
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    if (d > 8'd26) sh = 27'd1;
    else begin
      sh    = my >> d;
      sh[0] = sh[0] | (|(my & ~({27{1'b1}} << d)));
    end
    e = {2'b00, x[30:23]};
    s = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, sh}) : ({1'b0, mx} - {1'b0, sh});
    if (s == 28'd0) return 32'd0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'sd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!s[26]) begin s = s << 1; e = e - 10'sd1; end
      end
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    m   = {1'b0, s[26:3]} + {24'd0, rnd};
    if (m[24]) begin m = m >> 1; e = e + 10'sd1; end
    if (e <= 10'sd0)   return {x[31], 31'd0};
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
    return {x[31], e[7:0], m[22:0]};
  endfunction

  state_e            state_q, state_d;
  logic [31:0]       w_q     [NUM_W];
  logic [31:0]       img_q   [NUM_PIX];
  logic [31:0]       stage_q [NUM_SLOT];
  logic [31:0]       acc_q, pool_q;
  logic [1:0]        pr_q, k_q, pc_q, win_q;
  logic [3:0]        tap_q;

  logic [1:0]        tap_row, tap_col;
  logic [2:0]        pix_r, pix_c;
  logic [WI_W-1:0]   widx;
  logic [SI_W-1:0]   slot;
  logic [31:0]       prod, sum, pool_base, pool_new;
  logic              last_tap, last_win, last_slot, last_row;
  logic [12*DATA_WIDTH-1:0] row_bus;

  always_comb begin
    tap_row   = 2'(tap_q / 4'd3);
    tap_col   = 2'(tap_q % 4'd3);
    pix_r     = {pr_q, win_q[1]} + {1'b0, tap_row};
    pix_c     = {pc_q, win_q[0]} + {1'b0, tap_col};
    widx      = WI_W'({4'd0, k_q} * 6'd9 + {2'd0, tap_q});
    slot      = SI_W'({2'd0, k_q} * 4'd3 + {2'd0, pc_q});
    prod      = fp_mul(w_q[widx], img_q[PI_W'({pix_r, pix_c})]);
    sum       = fp_add(acc_q, prod);
    // The first window of a pooled cell compares against +0.0, which also implements ReLU.
    pool_base = (win_q == 2'd0) ? 32'd0 : pool_q;
    pool_new  = (!sum[31] && (sum[30:0] > pool_base[30:0])) ? sum : pool_base;
    last_tap  = (tap_q == 4'd8);
    last_win  = last_tap && (win_q == 2'd3);
    last_slot = last_win && (k_q == 2'd3) && (pc_q == 2'd2);
    last_row  = last_slot && (pr_q == 2'd2);
    row_bus   = '0;
    for (int i = 0; i < NUM_SLOT; i++) begin
      row_bus[(NUM_SLOT - i) * DATA_WIDTH - 1 -: DATA_WIDTH] =
        (SI_W'(i) == slot) ? pool_new : stage_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (enable)                  state_d = S_LOAD_W;
      S_LOAD_W:   if (ext_rom_addr == W_LAST)   state_d = S_LOAD_IMG;
      S_LOAD_IMG: if (ext_rom_addr == IMG_LAST) state_d = S_COMPUTE;
      S_COMPUTE:  if (last_row)                state_d = S_DONE;
      S_DONE:                                  state_d = S_IDLE;
      default:                                 state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_rom_addr   <= '0;
      pooling_output <= '0;
      acc_q          <= '0;
      pool_q         <= '0;
      pr_q           <= '0;
      k_q            <= '0;
      pc_q           <= '0;
      win_q          <= '0;
      tap_q          <= '0;
      for (int i = 0; i < NUM_W; i++)    w_q[i]     <= '0;
      for (int i = 0; i < NUM_PIX; i++)  img_q[i]   <= '0;
      for (int i = 0; i < NUM_SLOT; i++) stage_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (enable) begin
          ext_rom_addr <= '0;
          acc_q        <= '0;
          pr_q         <= '0;
          k_q          <= '0;
          pc_q         <= '0;
          win_q        <= '0;
          tap_q        <= '0;
        end
        S_LOAD_W: begin
          w_q[ext_rom_addr[WI_W-1:0]] <= data_in;
          ext_rom_addr <= ext_rom_addr + 1'b1;
        end
        S_LOAD_IMG: begin
          img_q[PI_W'(ext_rom_addr - IMG_BASE)] <= data_in;
          if (ext_rom_addr != IMG_LAST) ext_rom_addr <= ext_rom_addr + 1'b1;
        end
        S_COMPUTE: begin
          acc_q <= last_tap ? 32'd0 : sum;
          tap_q <= last_tap ? 4'd0 : tap_q + 4'd1;
          if (last_tap) begin
            pool_q <= pool_new;
            win_q  <= win_q + 2'd1;
          end
          if (last_win) begin
            stage_q[slot] <= pool_new;
            pc_q <= (pc_q == 2'd2) ? 2'd0 : pc_q + 2'd1;
            if (pc_q == 2'd2) k_q <= k_q + 2'd1;
          end
          if (last_slot) begin
            pooling_output <= row_bus;
            pr_q <= (pr_q == 2'd2) ? 2'd0 : pr_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mnist_conv_pool.sv
`default_nettype none
// ==========================================================================
// tb_mnist_conv_pool : directed self-checking bench for mnist_conv_pool
// Revision: 1.0
// ==========================================================================
module tb_mnist_conv_pool;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [31:0]   data_in;
  logic [11:0]   ext_rom_addr;
  logic [383:0]  pooling_output;

  logic [31:0]   rom [128];
  logic [31:0]   exp_rows [3][12];
  int            n_checks;
  int            n_pass;

  mnist_conv_pool dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .data_in        (data_in),
    .ext_rom_addr   (ext_rom_addr),
    .pooling_output (pooling_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_in = (ext_rom_addr < 12'd100) ? rom[ext_rom_addr[6:0]] : 32'd0;

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] int_to_fp(input int v);
    int          p;
    logic [31:0] u;
    if (v == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 31; i++) if (v >= (1 << i)) p = i;
    u = v;
    u = u << (23 - p);
    return {1'b0, 8'(127 + p), u[22:0]};
  endfunction

  // center=1: kernel 0 has only its centre tap at 1.0, pixel (r,c) = r*8+c.
  task automatic fill_rom(input logic [31:0] wv, input bit center);
    for (int a = 0; a < 128; a++) rom[a] = 32'd0;
    for (int a = 0; a < 36; a++)
      rom[a] = center ? ((a == 4) ? 32'h3F800000 : 32'd0) : wv;
    for (int a = 36; a < 100; a++)
      rom[a] = center ? int_to_fp(a - 36) : 32'h3F800000;
  endtask

  task automatic set_exp_all(input logic [31:0] v);
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 12; s++) exp_rows[r][s] = v;
  endtask

  task automatic set_exp_center();
    logic [31:0] ctr [3][3];
    ctr = '{'{32'h41900000, 32'h41A00000, 32'h41B00000},
            '{32'h42080000, 32'h42100000, 32'h42180000},
            '{32'h42480000, 32'h42500000, 32'h42580000}};
    set_exp_all(32'd0);
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 3; s++) exp_rows[r][s] = ctr[r][s];
  endtask

  task automatic check_row(input string name, input int r);
    for (int s = 0; s < 12; s++)
      check($sformatf("%s_row%0d_slot%0d", name, r, s),
            {352'd0, pooling_output[383 - 32*s -: 32]}, {352'd0, exp_rows[r][s]});
  endtask

  task automatic run_and_check(input string name, input bit disturb);
    int n;
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    n = 0;
    while (ext_rom_addr != 12'd99 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_load_done"}, {372'd0, ext_rom_addr}, {372'd0, 12'd99});
    if (disturb) begin
      repeat (100) @(negedge clk);
      enable = 1'b1;
      @(negedge clk) enable = 1'b0;
      repeat (351) @(negedge clk);
    end else begin
      repeat (452) @(negedge clk);
    end
    check_row(name, 0);
    repeat (432) @(negedge clk);
    check_row(name, 1);
    repeat (432) @(negedge clk);
    check_row(name, 2);
    repeat (20) @(negedge clk);
    check({name, "_addr_hold"}, {372'd0, ext_rom_addr}, {372'd0, 12'd99});
    check_row({name, "_retained"}, 2);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    fill_rom(32'h3F800000, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_addr", {372'd0, ext_rom_addr}, 384'd0);
    check("reset_bus", pooling_output, 384'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_addr", {372'd0, ext_rom_addr}, 384'd0);
    check("idle_bus", pooling_output, 384'd0);

    set_exp_all(32'h41100000);
    run_and_check("ones", 1'b0);

    fill_rom(32'hBF800000, 1'b0);
    set_exp_all(32'd0);
    run_and_check("neg", 1'b0);

    fill_rom(32'd0, 1'b1);
    set_exp_center();
    run_and_check("center", 1'b0);
    run_and_check("center_en", 1'b1);

    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    n = 0;
    while (ext_rom_addr != 12'd50 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_img", {372'd0, ext_rom_addr}, {372'd0, 12'd50});
    rst_n = 1'b0;
    #1;
    check("abort_addr", {372'd0, ext_rom_addr}, 384'd0);
    check("abort_bus", pooling_output, 384'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_and_check("center_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
